uart_rx_ctrl: RTL and testbench

Parametrised receiver control unit for the serial receiver path. It sits between the start-bit detector, the bit timer and the receive data buffer. Beyond sequencing a packet it supports configurable data width, optional parity, one or two stop bits, and error reporting: framing, parity and overrun. It counts bits and checks parity and stop bits internally, so no external stop-bit checker is needed.

---
 rtl/uart_rx_ctrl.sv | 140 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Receiver control unit: sequences one serial packet (data, optional parity,
// stop bits), checks parity and stop bits, and manages the receive buffer
// status and error flags.
module uart_rx_ctrl #(
    parameter int unsigned NUM_DATA_BITS = 8,
    parameter int unsigned PARITY_EN     = 0,
    parameter int unsigned PARITY_ODD    = 0,
    parameter int unsigned NUM_STOP_BITS = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic start_bit_detected,
    input  logic shift_strobe,
    input  logic serial_in,
    input  logic data_read,
    output logic sbc_clear,
    output logic enable_timer,
    output logic shift_enable,
    output logic load_buffer,
    output logic data_ready,
    output logic framing_error,
    output logic parity_error,
    output logic overrun_error
);

    localparam int unsigned CntW = $clog2(NUM_DATA_BITS + 1);
    localparam logic [CntW-1:0] LastData = CntW'(NUM_DATA_BITS - 1);
    localparam logic [CntW-1:0] LastStop = CntW'(NUM_STOP_BITS - 1);
    localparam logic OddBit = (PARITY_ODD != 0);
    localparam bit HasParity = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StReadData,
        StReadParity,
        StReadStop,
        StCheck,
        StLoadBuf
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            acc_q;
    logic            data_ready_q;
    logic            framing_q;
    logic            parity_q;
    logic            overrun_q;

    // Packet sequencing, bit/stop counting, parity accumulation and status flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            data_ready_q <= 1'b0;
            framing_q    <= 1'b0;
            parity_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            // Consumer read; LOAD_BUF below overrides data_ready.
            if (data_read) begin
                data_ready_q <= 1'b0;
                overrun_q    <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (start_bit_detected) begin
                        state_q <= StClear;
                    end
                end
                StClear: begin
                    cnt_q     <= '0;
                    acc_q     <= 1'b0;
                    framing_q <= 1'b0;
                    parity_q  <= 1'b0;
                    state_q   <= StReadData;
                end
                StReadData: begin
                    if (shift_strobe) begin
                        acc_q <= acc_q ^ serial_in;
                        if (cnt_q == LastData) begin
                            cnt_q   <= '0;
                            state_q <= HasParity ? StReadParity : StReadStop;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StReadParity: begin
                    if (shift_strobe) begin
                        if ((acc_q ^ serial_in) != OddBit) begin
                            parity_q <= 1'b1;
                        end
                        state_q <= StReadStop;
                    end
                end
                StReadStop: begin
                    if (shift_strobe) begin
                        if (!serial_in) begin
                            framing_q <= 1'b1;
                        end
                        if (cnt_q == LastStop) begin
                            cnt_q   <= '0;
                            state_q <= StCheck;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StCheck: begin
                    state_q <= (framing_q || parity_q) ? StIdle : StLoadBuf;
                end
                StLoadBuf: begin
                    data_ready_q <= 1'b1;
                    if (data_ready_q && !data_read) begin
                        overrun_q <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Moore decodes of the registered state; shift_enable passes the strobe through.
    assign sbc_clear     = (state_q == StClear);
    assign enable_timer  = (state_q == StReadData) || (state_q == StReadParity) ||
                           (state_q == StReadStop);
    assign load_buffer   = (state_q == StLoadBuf);
    assign shift_enable  = shift_strobe && (state_q == StReadData);
    assign data_ready    = data_ready_q;
    assign framing_error = framing_q;
    assign parity_error  = parity_q;
    assign overrun_error = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: one default instance (8N1) and one instance with
// 5 data bits, even parity and two stop bits, checked against a scoreboard.
module tb_uart_rx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst_a, sbd_a, stb_a, ser_a, rd_a;
    logic clr_a, en_a, se_a, lb_a, dr_a, fe_a, pe_a, ov_a;
    logic n_rst_b, sbd_b, stb_b, ser_b, rd_b;
    logic clr_b, en_b, se_b, lb_b, dr_b, fe_b, pe_b, ov_b;

    uart_rx_ctrl #(
        .NUM_DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .NUM_STOP_BITS(1)
    ) u_dut_a (
        .clk(clk), .n_rst(n_rst_a), .start_bit_detected(sbd_a), .shift_strobe(stb_a),
        .serial_in(ser_a), .data_read(rd_a), .sbc_clear(clr_a), .enable_timer(en_a),
        .shift_enable(se_a), .load_buffer(lb_a), .data_ready(dr_a),
        .framing_error(fe_a), .parity_error(pe_a), .overrun_error(ov_a)
    );

    uart_rx_ctrl #(
        .NUM_DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(0), .NUM_STOP_BITS(2)
    ) u_dut_b (
        .clk(clk), .n_rst(n_rst_b), .start_bit_detected(sbd_b), .shift_strobe(stb_b),
        .serial_in(ser_b), .data_read(rd_b), .sbc_clear(clr_b), .enable_timer(en_b),
        .shift_enable(se_b), .load_buffer(lb_b), .data_ready(dr_b),
        .framing_error(fe_b), .parity_error(pe_b), .overrun_error(ov_b)
    );

    typedef struct {
        logic ready;
        logic fe;
        logic pe;
        logic ov;
        logic load;
        int   shifts;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_load_a = 0, n_load_b = 0, n_shift_a = 0, n_shift_b = 0;
    logic m_ready [2];
    logic m_ov    [2];

    // Pulse counters for load_buffer and shift_enable.
    always @(posedge clk) begin
        if (lb_a) n_load_a <= n_load_a + 1;
        if (lb_b) n_load_b <= n_load_b + 1;
        if (se_a) n_shift_a <= n_shift_a + 1;
        if (se_b) n_shift_b <= n_shift_b + 1;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic sbd, input logic stb, input logic ser,
                         input logic rd);
        if (sel == 0) begin
            sbd_a = sbd; stb_a = stb; ser_a = ser; rd_a = rd;
        end else begin
            sbd_b = sbd; stb_b = stb; ser_b = ser; rd_b = rd;
        end
    endtask

    // Bit order: 7 clr, 6 en, 5 se, 4 lb, 3 dr, 2 fe, 1 pe, 0 ov.
    task automatic get_out(input int sel, output logic [7:0] o);
        if (sel == 0) o = {clr_a, en_a, se_a, lb_a, dr_a, fe_a, pe_a, ov_a};
        else          o = {clr_b, en_b, se_b, lb_b, dr_b, fe_b, pe_b, ov_b};
    endtask

    // One bit period: three idle cycles then a strobe cycle. Optionally injects a
    // start pulse that must be ignored.
    task automatic send_bit(input int sel, input logic b, input logic spurious);
        logic [7:0] o;
        for (int j = 0; j < 3; j++) begin
            drive(sel, spurious && (j == 0), 1'b0, b, 1'b0);
            if (spurious && (j == 1)) begin
                get_out(sel, o);
                check_val("start_ignored", int'(o[7]), 0);
                check_val("timer_kept", int'(o[6]), 1);
            end
            tick();
        end
        drive(sel, 1'b0, 1'b1, b, 1'b0);
        tick();
    endtask

    task automatic send_packet(input int sel, input logic [8:0] data, input logic pbit,
                               input logic st0, input logic st1, input logic rd_at_load,
                               input logic spurious);
        int         nbits;
        int         nstop;
        logic       use_par;
        logic       acc;
        logic       accepted;
        int         ld0, sh0, ld1, sh1;
        logic [7:0] o;
        exp_t       e;
        nbits   = (sel == 0) ? 8 : 5;
        nstop   = (sel == 0) ? 1 : 2;
        use_par = (sel == 1);
        acc     = 1'b0;
        for (int i = 0; i < nbits; i++) acc = acc ^ data[i];
        e.fe     = !st0 || ((nstop == 2) && !st1);
        e.pe     = use_par && ((acc ^ pbit) != 1'b0);
        accepted = !e.fe && !e.pe;
        if (accepted) begin
            m_ov[sel]    = (m_ready[sel] && !rd_at_load) ? 1'b1 : (rd_at_load ? 1'b0 : m_ov[sel]);
            m_ready[sel] = 1'b1;
        end else if (rd_at_load) begin
            m_ov[sel]    = 1'b0;
            m_ready[sel] = 1'b0;
        end
        e.ready  = m_ready[sel];
        e.ov     = m_ov[sel];
        e.load   = accepted;
        e.shifts = nbits;
        sb_q.push_back(e);

        ld0 = (sel == 0) ? n_load_a : n_load_b;
        sh0 = (sel == 0) ? n_shift_a : n_shift_b;
        drive(sel, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(sel, 1'b0, 1'b0, 1'b1, 1'b0);
        get_out(sel, o);
        check_val("sbc_clear", int'(o[7]), 1);
        check_val("timer_in_clear", int'(o[6]), 0);
        tick();
        get_out(sel, o);
        check_val("timer_latency", int'(o[6]), 1);
        for (int i = 0; i < nbits; i++) send_bit(sel, data[i], spurious && (i == 2));
        if (use_par) send_bit(sel, pbit, 1'b0);
        send_bit(sel, st0, 1'b0);
        if (nstop == 2) send_bit(sel, st1, 1'b0);
        drive(sel, 1'b0, 1'b0, 1'b1, 1'b0);
        get_out(sel, o);
        check_val("load_in_check", int'(o[4]), 0);
        tick();
        drive(sel, 1'b0, 1'b0, 1'b1, rd_at_load);
        get_out(sel, o);
        check_val("load_buffer", int'(o[4]), int'(accepted));
        tick();
        drive(sel, 1'b0, 1'b0, 1'b1, 1'b0);

        e   = sb_q.pop_front();
        ld1 = (sel == 0) ? n_load_a : n_load_b;
        sh1 = (sel == 0) ? n_shift_a : n_shift_b;
        get_out(sel, o);
        check_val("data_ready", int'(o[3]), int'(e.ready));
        check_val("framing_error", int'(o[2]), int'(e.fe));
        check_val("parity_error", int'(o[1]), int'(e.pe));
        check_val("overrun_error", int'(o[0]), int'(e.ov));
        check_val("load_count", ld1 - ld0, int'(e.load));
        check_val("shift_count", sh1 - sh0, e.shifts);
        check_val("timer_off", int'(o[6]), 0);
    endtask

    task automatic read_byte(input int sel);
        logic [7:0] o;
        drive(sel, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(sel, 1'b0, 1'b0, 1'b1, 1'b0);
        m_ready[sel] = 1'b0;
        m_ov[sel]    = 1'b0;
        get_out(sel, o);
        check_val("read_ready", int'(o[3]), 0);
        check_val("read_overrun", int'(o[0]), 0);
    endtask

    task automatic idle_hold(input int sel, input int ncyc, input logic fe, input logic pe);
        logic [7:0] o;
        for (int i = 0; i < ncyc; i++) tick();
        get_out(sel, o);
        check_val("flag_hold_fe", int'(o[2]), int'(fe));
        check_val("flag_hold_pe", int'(o[1]), int'(pe));
    endtask

    initial begin
        logic [7:0] o;
        m_ready[0] = 1'b0; m_ready[1] = 1'b0;
        m_ov[0] = 1'b0;    m_ov[1] = 1'b0;
        n_rst_a = 1'b0; n_rst_b = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        get_out(0, o);
        check_val("reset_a", int'(o), 0);
        get_out(1, o);
        check_val("reset_b", int'(o), 0);
        n_rst_a = 1'b1; n_rst_b = 1'b1;
        tick();

        // 8N1 instance: clean byte, overrun, read, read during load, framing error.
        send_packet(0, 9'h0A5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_packet(0, 9'h03C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        read_byte(0);
        send_packet(0, 9'h05A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_packet(0, 9'h0C3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send_packet(0, 9'h081, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_hold(0, 4, 1'b1, 1'b0);
        read_byte(0);

        // 5E2 instance: parity fail/pass, second stop bit low, recovery.
        send_packet(1, 9'h007, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_hold(1, 3, 1'b0, 1'b1);
        send_packet(1, 9'h007, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_packet(1, 9'h015, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_hold(1, 5, 1'b1, 1'b0);
        send_packet(1, 9'h00A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset in the middle of the data bits.
        drive(1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        send_bit(1, 1'b1, 1'b0);
        send_bit(1, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        n_rst_b = 1'b0;
        #1;
        get_out(1, o);
        check_val("async_reset_b", int'(o), 0);
        tick();
        n_rst_b = 1'b1;
        m_ready[1] = 1'b0;
        m_ov[1]    = 1'b0;
        tick();
        send_packet(1, 9'h011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        check_val("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
